// File: rtl/par_io_responder.sv
// par_io_responder: peripheral-side parallel I/O port.
// The bus master reads STATUS/RXBUF and writes TXBUF through s_/ior_/iow_/addr/data.
// An external producer fills RXBUF and an external consumer drains TXBUF, both over
// a dav_/rfd handshake.
// Handshake semantics (both ports): the receiver raises rfd when it can take a byte;
// the sender then drives data and pulls dav_ low; the receiver drops rfd once it has
// the byte; the sender releases dav_ high, which completes the transfer.
module par_io_responder #(
  parameter int WIDTH = 8,
  parameter bit SYNC  = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_,
  input  logic             ior_,
  input  logic             iow_,
  input  logic [1:0]       addr,
  inout  wire  [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dav_,
  output logic             in_rfd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_dav_,
  input  logic             out_rfd
);

  typedef enum logic [1:0] {I_IDLE, I_WDAV, I_WRD} i_state_t;
  typedef enum logic [1:0] {O_IDLE, O_WRFD, O_WACK, O_END} o_state_t;

  i_state_t         r_i_state, w_i_next;
  o_state_t         r_o_state, w_o_next;
  logic             r_fi, r_tx_busy, r_rd01_q, r_wr11_q, r_in_rfd, r_out_dav_;
  logic [WIDTH-1:0] r_rxbuf, r_txbuf, w_rd_val;
  logic             w_dav_s, w_rfd_s, w_rd_sel, w_rd01, w_wr11, w_wr_ev, w_fi_clr;
  logic             w_latch, w_tx_done;

  // Handshake inputs come from another clock domain unless SYNC is cleared.
  generate
    if (SYNC) begin : g_sync
      logic [1:0] r_dav_sync, r_rfd_sync;
      // Two-flop synchronizers; reset to the idle (deasserted) levels.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_dav_sync <= 2'b11;
          r_rfd_sync <= 2'b00;
        end else begin
          r_dav_sync <= {r_dav_sync[0], in_dav_};
          r_rfd_sync <= {r_rfd_sync[0], out_rfd};
        end
      end
      assign w_dav_s = r_dav_sync[1];
      assign w_rfd_s = r_rfd_sync[1];
    end else begin : g_nosync
      assign w_dav_s = in_dav_;
      assign w_rfd_s = out_rfd;
    end
  endgenerate

  // Bus decode. A simultaneous read and write is served as a read only.
  assign w_rd_sel = !s_ && !ior_;
  assign w_rd01   = w_rd_sel && (addr == 2'b01);
  assign w_wr11   = !s_ && !iow_ && ior_ && (addr == 2'b11);
  assign w_wr_ev  = w_wr11 && !r_wr11_q;
  assign w_fi_clr = r_rd01_q && !w_rd01;

  // Combinational register read mux.
  always_comb begin
    w_rd_val = '0;
    case (addr)
      2'b00:   w_rd_val = {{(WIDTH-2){1'b0}}, r_tx_busy, r_fi};
      2'b01:   w_rd_val = r_rxbuf;
      default: w_rd_val = '0;
    endcase
  end

  assign data     = w_rd_sel ? w_rd_val : 'z;
  assign in_rfd   = r_in_rfd;
  assign out_dav_ = r_out_dav_;
  assign out_data = r_txbuf;

  // Input FSM next state; a byte is latched only from I_IDLE, where fi is always 0.
  always_comb begin
    w_i_next = r_i_state;
    w_latch  = 1'b0;
    case (r_i_state)
      I_IDLE: if (!w_dav_s) begin
        w_latch  = 1'b1;
        w_i_next = I_WDAV;
      end
      I_WDAV: if (w_dav_s) w_i_next = r_fi ? I_WRD : I_IDLE;
      I_WRD:  if (!r_fi) w_i_next = I_IDLE;
      default: w_i_next = I_IDLE;
    endcase
  end

  // Output FSM next state; tx_busy is released only when the consumer is ready again.
  always_comb begin
    w_o_next  = r_o_state;
    w_tx_done = 1'b0;
    case (r_o_state)
      O_IDLE: if (r_tx_busy) w_o_next = O_WRFD;
      O_WRFD: if (w_rfd_s) w_o_next = O_WACK;
      O_WACK: if (!w_rfd_s) w_o_next = O_END;
      O_END:  if (w_rfd_s) begin
        w_tx_done = 1'b1;
        w_o_next  = O_IDLE;
      end
      default: w_o_next = O_IDLE;
    endcase
  end

  // State registers and registered handshake outputs (no input-to-output comb path).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_state  <= I_IDLE;
      r_o_state  <= O_IDLE;
      r_in_rfd   <= 1'b1;
      r_out_dav_ <= 1'b1;
    end else begin
      r_i_state  <= w_i_next;
      r_o_state  <= w_o_next;
      r_in_rfd   <= (w_i_next == I_IDLE);
      r_out_dav_ <= (w_o_next != O_WACK);
    end
  end

  // Receive side: latch producer byte, clear fi at the end of an RXBUF read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxbuf  <= '0;
      r_fi     <= 1'b0;
      r_rd01_q <= 1'b0;
    end else begin
      r_rd01_q <= w_rd01;
      if (w_latch) begin
        r_rxbuf <= in_data;
        r_fi    <= 1'b1;
      end else if (w_fi_clr) begin
        r_fi <= 1'b0;
      end
    end
  end

  // Transmit side: one event per write strobe; writes while busy are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_txbuf   <= '0;
      r_tx_busy <= 1'b0;
      r_wr11_q  <= 1'b0;
    end else begin
      r_wr11_q <= w_wr11;
      if (w_tx_done) begin
        r_tx_busy <= 1'b0;
      end else if (w_wr_ev && !r_tx_busy) begin
        r_txbuf   <= data;
        r_tx_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_par_io_responder.sv
// Testbench for par_io_responder: bus reads and transmitted bytes are checked by
// monitors against expected queues filled from a transaction-level model.
module tb_par_io_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s_ = 1'b1, ior_ = 1'b1, iow_ = 1'b1;
  logic [1:0] addr = 2'b00;
  logic [7:0] in_data = 8'h00;
  logic       in_dav_ = 1'b1;
  logic       out_rfd = 1'b0;
  wire        in_rfd;
  wire  [7:0] out_data;
  wire        out_dav_;
  wire  [7:0] data;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = 8'h00;

  assign data = drv_en ? drv_val : 8'bz;

  par_io_responder #(.WIDTH(8), .SYNC(1'b1)) dut (
    .clock(clock), .reset(reset), .s_(s_), .ior_(ior_), .iow_(iow_), .addr(addr),
    .data(data), .in_data(in_data), .in_dav_(in_dav_), .in_rfd(in_rfd),
    .out_data(out_data), .out_dav_(out_dav_), .out_rfd(out_rfd)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  int tx_pushed = 0;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];
  logic       rd_active = 1'b0;

  // Transaction-level reference model
  logic [7:0] m_rx = 8'h00;
  logic [7:0] m_txbuf = 8'h00;
  logic       m_fi = 1'b0;
  logic       m_busy = 1'b0;

  function automatic logic [7:0] m_status();
    return {6'b0, m_busy, m_fi};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: bus read monitor, samples 2 time units after the edge
  always @(posedge clock) begin
    #2;
    if (rd_active) begin
      if (rd_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h with empty queue", data);
      end else begin
        check(rd_name_q.pop_front(), data, rd_exp_q.pop_front());
      end
    end
  end

  // scoreboard: consumer-side monitor, one byte per falling out_dav_
  always @(negedge out_dav_) begin
    #1;
    tx_seen++;
    if (tx_exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL tx_unexpected: got %h with empty queue", out_data);
    end else begin
      check("tx_byte", out_data, tx_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string name);
    @(negedge clock);
    addr = a; s_ = 1'b0; ior_ = 1'b0;
    rd_exp_q.push_back(exp); rd_name_q.push_back(name);
    rd_active = 1'b1;
    @(negedge clock);
    s_ = 1'b1; ior_ = 1'b1; rd_active = 1'b0;
    if (a == 2'b01) m_fi = 1'b0;
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] v, input int hold);
    @(negedge clock);
    addr = a; drv_val = v; drv_en = 1'b1; s_ = 1'b0; iow_ = 1'b0;
    repeat (hold) @(negedge clock);
    s_ = 1'b1; iow_ = 1'b1; drv_en = 1'b0;
    if (a == 2'b11 && !m_busy) begin
      m_busy = 1'b1; m_txbuf = v;
      tx_exp_q.push_back(v); tx_pushed++;
    end
  endtask

  task automatic wait_in_rfd(input logic v, input int bound, input string name);
    int n = 0;
    while (in_rfd !== v && n < bound) begin @(negedge clock); n++; end
    check(name, {7'b0, in_rfd}, {7'b0, v});
  endtask

  task automatic wait_out_dav(input logic v, input int bound, input string name);
    int n = 0;
    while (out_dav_ !== v && n < bound) begin @(negedge clock); n++; end
    check(name, {7'b0, out_dav_}, {7'b0, v});
  endtask

  // producer presents a byte and waits for it to be taken
  task automatic produce(input logic [7:0] v);
    @(negedge clock);
    in_data = v; in_dav_ = 1'b0;
    @(negedge clock);
    wait_in_rfd(1'b0, 3, "rx_rfd_low");
    m_rx = v; m_fi = 1'b1;
  endtask

  task automatic release_dav();
    in_dav_ = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // consumer completes one transfer
  task automatic consume();
    out_rfd = 1'b1;
    wait_out_dav(1'b0, 10, "tx_dav_low");
    out_rfd = 1'b0;
    wait_out_dav(1'b1, 10, "tx_dav_high");
    out_rfd = 1'b1;
    repeat (5) @(negedge clock);
    m_busy = 1'b0;
  endtask

  initial begin
    logic [7:0] v, w;
    // 1. reset
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    check("rst_in_rfd", {7'b0, in_rfd}, 8'h01);
    check("rst_out_dav", {7'b0, out_dav_}, 8'h01);
    drv_en = 1'b1; drv_val = 8'hA5; ior_ = 1'b0;
    @(negedge clock);
    check("deselect_hiz", data, 8'hA5);
    drv_en = 1'b0; ior_ = 1'b1;
    bus_read(2'b00, 8'h00, "rst_status");
    bus_read(2'b01, 8'h00, "rst_rxbuf");

    // 2. receive byte
    produce(8'h2F);
    bus_read(2'b00, m_status(), "rx_status_fi");
    release_dav();
    bus_read(2'b01, m_rx, "rx_rxbuf");
    bus_read(2'b00, m_status(), "rx_status_clr");
    wait_in_rfd(1'b1, 4, "rx_rfd_back");
    bus_read(2'b01, 8'h2F, "rx_stale");

    // 3. back-pressure
    produce(8'h11);
    release_dav();
    in_data = 8'h22; in_dav_ = 1'b0;
    repeat (8) @(negedge clock);
    check("bp_rfd_low", {7'b0, in_rfd}, 8'h00);
    bus_read(2'b00, m_status(), "bp_status");
    bus_read(2'b01, 8'h11, "bp_rxbuf_old");
    repeat (6) @(negedge clock);
    m_rx = 8'h22; m_fi = 1'b1;
    bus_read(2'b00, m_status(), "bp_status2");
    release_dav();
    bus_read(2'b01, m_rx, "bp_rxbuf_new");

    // 4. transmit byte
    out_rfd = 1'b1; repeat (3) @(negedge clock);
    bus_write(2'b11, 8'hF3, 1);
    check("tx_out_data", out_data, m_txbuf);
    bus_read(2'b00, m_status(), "tx_status_busy");
    consume();
    bus_read(2'b00, m_status(), "tx_status_done");

    // 5. busy write dropped, held write single event
    out_rfd = 1'b0; repeat (3) @(negedge clock);
    bus_write(2'b11, 8'h55, 1);
    bus_write(2'b11, 8'hAA, 1);
    check("drop_out_data", out_data, m_txbuf);
    bus_read(2'b00, m_status(), "drop_status");
    consume();
    out_rfd = 1'b0; repeat (3) @(negedge clock);
    bus_write(2'b11, 8'h77, 10);
    consume();
    repeat (10) @(negedge clock);
    bus_read(2'b00, m_status(), "hold_status");

    // randomized traffic
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom_range(0, 255));
      produce(v);
      bus_read(2'b00, m_status(), "rnd_status_fi");
      release_dav();
      bus_read(2'($urandom_range(2, 3)), 8'h00, "rnd_unused_rd");
      bus_read(2'b01, m_rx, "rnd_rxbuf");
      out_rfd = 1'b0; repeat (3) @(negedge clock);
      bus_write(2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 1);
      check("rnd_ignored_wr", out_data, m_txbuf);
      w = 8'($urandom_range(0, 255));
      bus_write(2'b11, w, 1);
      if ($urandom_range(0, 1) == 1) bus_write(2'b11, ~w, 1);
      check("rnd_out_data", out_data, m_txbuf);
      bus_read(2'b00, m_status(), "rnd_status_busy");
      consume();
      bus_read(2'b00, m_status(), "rnd_status_idle");
    end

    // 6. mid-operation reset
    produce(8'h3C);
    release_dav();
    out_rfd = 1'b1; repeat (3) @(negedge clock);
    bus_write(2'b11, 8'h99, 1);
    wait_out_dav(1'b0, 10, "mid_dav_low");
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_out_dav", {7'b0, out_dav_}, 8'h01);
    check("mid_in_rfd", {7'b0, in_rfd}, 8'h01);
    @(negedge clock); reset = 1'b0;
    m_fi = 1'b0; m_busy = 1'b0; m_rx = 8'h00; m_txbuf = 8'h00;
    out_rfd = 1'b0;
    bus_read(2'b00, m_status(), "mid_status");
    bus_read(2'b01, m_rx, "mid_rxbuf");
    check("mid_out_data", out_data, m_txbuf);

    // final report
    repeat (5) @(negedge clock);
    check("rd_q_empty", 8'(rd_exp_q.size()), 8'h00);
    check("tx_q_empty", 8'(tx_exp_q.size()), 8'h00);
    check("tx_count", 8'(tx_seen), 8'(tx_pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/par_io_responder.md
Name: par_io_responder

Overview:
- Synthesizable peripheral-side parallel I/O interface, addressed by the bus master through `s_`, `ior_`, `iow_`, `addr[1:0]` and `data[7:0]`.
- Replaces the behavioural interface model with real hardware.
- Input port: receives bytes from an external producer over a `dav_`/`rfd` handshake and exposes them through a status/receive-buffer register pair.
- Output port: transmits bytes the master writes at address 11 to an external consumer over the same handshake.

Parameters:
- WIDTH, 8, width of bus data, the receive buffer and the transmit buffer.
- SYNC, 1; 1 = two-flop synchronizers on `in_dav_` and `out_rfd`, 0 = use them directly.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s_  input  1  chip select, active low.
- ior_  input  1  bus read strobe, active low.
- iow_  input  1  bus write strobe, active low.
- addr  input  2  register select.
- data  inout  WIDTH  bidirectional bus; driven only during a selected read, otherwise high-Z.
- in_data  input  WIDTH  producer data.
- in_dav_  input  1  producer data-valid, active low.
- in_rfd  output  1  ready-for-data to the producer.
- out_data  output  WIDTH  consumer data (= TXBUF).
- out_dav_  output  1  data-valid to the consumer, active low.
- out_rfd  input  1  consumer ready-for-data.

Behaviour:
- Interface timing: one clock; reset is synchronous and active-high.
- Reset values: fi=0, tx_busy=0, RXBUF=0, TXBUF=0, input FSM I_IDLE (in_rfd=1), output FSM O_IDLE (out_dav_=1), `data` high-Z.
- Reset asserted mid-handshake aborts both FSMs; values above take effect at the next edge.
- Register map, reads are combinational while s_=0 and ior_=0:
  - 00 STATUS = {zeros, tx_busy, fi}.
  - 01 RXBUF.
  - 10 reads 0.
  - 11 reads 0.
- Writes:
  - Only address 11 is writable.
  - Writes to 00, 01 and 10 are ignored.
  - If ior_=0 and iow_=0 together, the block serves the read and ignores the write.
- Read event:
  - rd01 = !s_ & !ior_ & addr==01, registered as rd01_q.
  - The edge where rd01_q=1 and rd01=0 (end of access) clears fi.
  - Reading RXBUF while fi=0 returns the stale value with no side effect.
- Write event:
  - wr11 = !s_ & !iow_ & addr==11, registered as wr11_q.
  - First edge with wr11=1 and wr11_q=0: if tx_busy=0, TXBUF<=data and tx_busy<=1; if tx_busy=1, the write is dropped.
  - A held strobe produces exactly one event.
- Synchronized strobes: dav_s and rfd_s are in_dav_ and out_rfd after SYNC stages (2 edges of latency when SYNC=1, 0 when SYNC=0).
- Input FSM:
  - I_IDLE: in_rfd=1. When dav_s=0: RXBUF<=in_data, fi<=1, go to I_WDAV.
  - I_WDAV: in_rfd=0. Wait for dav_s=1. Then go to I_IDLE if fi=0 (master already read), else go to I_WRD.
  - I_WRD: in_rfd=0. Wait for fi=0, then go to I_IDLE.
  - Latch and clear cannot coincide, because latching happens only in I_IDLE with fi=0.
- Output FSM:
  - O_IDLE: out_dav_=1. When tx_busy goes to 1, go to O_WRFD.
  - O_WRFD: out_dav_=1. When rfd_s=1, go to O_WACK.
  - O_WACK: out_dav_=0. When rfd_s=0 (consumer took data), go to O_END.
  - O_END: out_dav_=1. When rfd_s=1, tx_busy<=0 and go to O_IDLE.
  - A write event in the same cycle as O_END→O_IDLE is dropped, since tx_busy is still 1 that cycle.
- Output data stability: out_data holds TXBUF and is stable from entering O_WRFD until return to O_IDLE.
- Registered outputs: in_rfd and out_dav_ are registered from FSM state, giving no combinational path from inputs.

Test Plan:
1. Reset check: reset=1 for 2 clocks, then read 00 and 01 -> STATUS=8'h00, RXBUF=8'h00, in_rfd=1, out_dav_=1, data high-Z when deselected.
2. Receive byte: drive in_data=8'h2F and in_dav_=0 -> within 3 edges (SYNC=1) in_rfd=0. Read 00 -> 8'h01. Release in_dav_=1, then read 01 -> 8'h2F. After the read ends, STATUS=8'h00 and in_rfd returns to 1.
3. Back-pressure: latch 8'h11 without reading RXBUF, release in_dav_, present 8'h22 with in_dav_=0 -> in_rfd stays 0 and RXBUF stays 8'h11. After reading 01 the block accepts 8'h22.
4. Transmit byte: out_rfd=1, write 8'hF3 at addr 11 -> STATUS=8'h02 and out_data=8'hF3. out_dav_=0 within 3 edges. Drop out_rfd -> out_dav_=1. Raise out_rfd -> STATUS=8'h00.
5. Busy write dropped: hold out_rfd=0, write 8'h55, then 8'hAA -> out_data stays 8'h55 and STATUS bit1=1. A write held for 10 clocks produces a single transfer.
6. Mid-operation reset: assert reset while out_dav_=0 and fi=1 -> at the next edge out_dav_=1, STATUS=8'h00, in_rfd=1.
